// File: rtl/tx_framer_mux.sv
// Transmit framer: wraps buffered packets in start/end characters and inserts
// periodic COM-led ordered sets between packets; idle symbols otherwise.
module tx_framer_mux #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned LEN_W        = 4,
    parameter int unsigned SKP_INTERVAL = 16,
    parameter int unsigned OS_LEN       = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pkt_req,
    input  logic [LEN_W-1:0]    pkt_len,
    output logic                pkt_ack,
    input  logic [DATA_W-1:0]   D_in,
    output logic                data_rd,
    input  logic [2*DATA_W-1:0] start_end,
    input  logic [DATA_W-1:0]   ordered_set,
    input  logic [DATA_W-1:0]   logical_COM,
    output logic [DATA_W-1:0]   D_out,
    output logic                valid,
    output logic                k_out,
    output logic                busy
);

    localparam int unsigned TMR_W = $clog2(SKP_INTERVAL);
    localparam int unsigned OS_W  = $clog2(OS_LEN);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(SKP_INTERVAL - 1);
    localparam logic [OS_W-1:0]  OS_START = OS_W'(OS_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OS   = 2'd1,
        DATA = 2'd2,
        ENDC = 2'd3
    } state_t;

    state_t             state;
    logic [TMR_W-1:0]   timer;
    logic [LEN_W-1:0]   len_cnt;
    logic [OS_W-1:0]    os_cnt;
    logic               skp_due;

    // Ordered-set insertion is due once the timer has saturated.
    assign skp_due = (timer == TMR_MAX);

    always_comb begin
        pkt_ack = 1'b0;
        data_rd = 1'b0;
        busy    = 1'b0;
        pkt_ack = (state == IDLE) && !skp_due && pkt_req;
        data_rd = (state == DATA);
        busy    = (state != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            timer   <= '0;
            len_cnt <= '0;
            os_cnt  <= '0;
            D_out   <= '0;
            valid   <= 1'b0;
            k_out   <= 1'b0;
        end else begin
            // Saturating timer; restarts on the edge that emits COM.
            if (state == IDLE && skp_due) begin
                timer <= '0;
            end else if (!skp_due) begin
                timer <= timer + TMR_W'(1);
            end

            case (state)
                IDLE: begin
                    if (skp_due) begin
                        D_out  <= logical_COM;
                        valid  <= 1'b0;
                        k_out  <= 1'b1;
                        os_cnt <= OS_START;
                        state  <= OS;
                    end else if (pkt_req) begin
                        D_out   <= start_end[DATA_W-1:0];
                        valid   <= 1'b0;
                        k_out   <= 1'b1;
                        len_cnt <= pkt_len;
                        state   <= (pkt_len != '0) ? DATA : ENDC;
                    end else begin
                        D_out <= '0;
                        valid <= 1'b0;
                        k_out <= 1'b0;
                    end
                end
                OS: begin
                    D_out  <= ordered_set;
                    valid  <= 1'b0;
                    k_out  <= 1'b1;
                    os_cnt <= os_cnt - OS_W'(1);
                    if (os_cnt == OS_W'(1)) begin
                        state <= IDLE;
                    end
                end
                DATA: begin
                    D_out   <= D_in;
                    valid   <= 1'b1;
                    k_out   <= 1'b0;
                    len_cnt <= len_cnt - LEN_W'(1);
                    if (len_cnt == LEN_W'(1)) begin
                        state <= ENDC;
                    end
                end
                ENDC: begin
                    D_out <= start_end[2*DATA_W-1:DATA_W];
                    valid <= 1'b0;
                    k_out <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    D_out <= '0;
                    valid <= 1'b0;
                    k_out <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_framer_mux.sv
// Scoreboard bench for tx_framer_mux: stimulus queues expected non-idle symbols,
// a negedge monitor pops and compares them; timing points are checked directly.
module tb_tx_framer_mux;

    localparam logic [7:0] START_C = 8'hFB;
    localparam logic [7:0] END_C   = 8'hFD;
    localparam logic [7:0] COM_C   = 8'hBC;
    localparam logic [7:0] FILL_C  = 8'hF7;

    typedef struct packed {
        logic [7:0] d;
        logic       v;
        logic       k;
    } sym_t;

    logic        clk;
    logic        reset;
    logic        pkt_req;
    logic [3:0]  pkt_len;
    logic        pkt_ack;
    logic [7:0]  din;
    logic        data_rd;
    logic [15:0] start_end;
    logic [7:0]  ordered_set;
    logic [7:0]  logical_com;
    logic [7:0]  d_out;
    logic        valid;
    logic        k_out;
    logic        busy;

    sym_t        exp_q[$];
    logic [7:0]  buffer[$];
    int          com_cyc[$];
    int          cyc;
    int          rd_cnt;
    int          n_cmp;
    int          n_bad;

    tx_framer_mux dut (
        .clk         (clk),
        .reset       (reset),
        .pkt_req     (pkt_req),
        .pkt_len     (pkt_len),
        .pkt_ack     (pkt_ack),
        .D_in        (din),
        .data_rd     (data_rd),
        .start_end   (start_end),
        .ordered_set (ordered_set),
        .logical_COM (logical_com),
        .D_out       (d_out),
        .valid       (valid),
        .k_out       (k_out),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Cycle count since reset release, and the transmit buffer model.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc    <= 0;
            rd_cnt <= 0;
        end else begin
            cyc <= cyc + 1;
            if (data_rd) begin
                rd_cnt <= rd_cnt + 1;
                if (buffer.size() > 0) void'(buffer.pop_front());
            end
            din <= (buffer.size() > 0) ? buffer[0] : 8'h00;
        end
    end

    // Monitor: every control or data symbol is matched against the scoreboard.
    always @(negedge clk) begin
        if (!reset && (valid || k_out)) begin
            if (k_out && d_out == COM_C) com_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_sym: got d=%0h v=%0b k=%0b, expected none (cycle %0d)",
                         d_out, valid, k_out, cyc);
            end else begin
                sym_t e;
                e = exp_q.pop_front();
                check("sym", {23'd0, d_out, valid, k_out}, {23'd0, e.d, e.v, e.k});
            end
        end
    end

    task automatic push_exp(input logic [7:0] d, input logic v, input logic k);
        sym_t s;
        s.d = d;
        s.v = v;
        s.k = k;
        exp_q.push_back(s);
    endtask

    task automatic push_os();
        push_exp(COM_C, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) push_exp(FILL_C, 1'b0, 1'b1);
    endtask

    task automatic wait_cyc(input int n);
        int guard;
        guard = 0;
        while (cyc < n && guard < 500) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (cyc < n) check("wait_timeout", 32'(cyc), 32'(n));
    endtask

    // Raise a request and hold it until acknowledged; checks the ack cycle.
    task automatic req_pkt(input int len, input int exp_ack_cyc);
        bit got;
        got = 1'b0;
        pkt_req = 1'b1;
        pkt_len = 4'(len);
        for (int i = 0; i < 40 && !got; i++) begin
            #1;
            if (pkt_ack) begin
                got = 1'b1;
                check("ack_cycle", 32'(cyc), 32'(exp_ack_cyc));
            end
            @(posedge clk);
            #1;
        end
        pkt_req = 1'b0;
        pkt_len = 4'hA;
        if (!got) check("ack_timeout", 32'(got), 32'd1);
    endtask

    task automatic check_com(input int idx, input int exp);
        if (com_cyc.size() > idx) check("com_cycle", 32'(com_cyc[idx]), 32'(exp));
        else check("com_missing", 32'(com_cyc.size()), 32'(idx + 1));
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        reset       = 1'b0;
        pkt_req     = 1'b0;
        pkt_len     = 4'd0;
        start_end   = {END_C, START_C};
        ordered_set = FILL_C;
        logical_com = COM_C;
        #1 reset = 1'b1;
        #1;
        check("rst_dout", 32'(d_out), 32'd0);
        check("rst_vk", {30'd0, valid, k_out}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;

        // Idle: first ordered set after 16 edges.
        push_os();
        wait_cyc(20);
        check_com(0, 16);

        // Single packet AA BB CC, then the next periodic ordered set.
        buffer.push_back(8'hAA);
        buffer.push_back(8'hBB);
        buffer.push_back(8'hCC);
        push_exp(START_C, 1'b0, 1'b1);
        push_exp(8'hAA, 1'b1, 1'b0);
        push_exp(8'hBB, 1'b1, 1'b0);
        push_exp(8'hCC, 1'b1, 1'b0);
        push_exp(END_C, 1'b0, 1'b1);
        push_os();
        req_pkt(3, 20);
        wait_cyc(36);
        check("rd_cnt_3", 32'(rd_cnt), 32'd3);
        check_com(1, 32);
        check("idle_out", {22'd0, d_out, valid, k_out, busy}, 32'd0);

        // Zero-length packet: start then end, no reads.
        push_exp(START_C, 1'b0, 1'b1);
        push_exp(END_C, 1'b0, 1'b1);
        req_pkt(0, 36);
        wait_cyc(40);
        check("rd_cnt_zero", 32'(rd_cnt), 32'd3);

        // Collision: request raised while the ordered set is due.
        wait_cyc(47);
        buffer.push_back(8'h11);
        buffer.push_back(8'h22);
        push_os();
        push_exp(START_C, 1'b0, 1'b1);
        push_exp(8'h11, 1'b1, 1'b0);
        push_exp(8'h22, 1'b1, 1'b0);
        push_exp(END_C, 1'b0, 1'b1);
        req_pkt(2, 51);
        check_com(2, 48);

        // Long packet accepted two cycles before the set is due.
        wait_cyc(61);
        push_exp(START_C, 1'b0, 1'b1);
        for (int i = 0; i < 15; i++) begin
            buffer.push_back(8'(8'h30 + i));
            push_exp(8'(8'h30 + i), 1'b1, 1'b0);
        end
        push_exp(END_C, 1'b0, 1'b1);
        push_os();
        req_pkt(15, 61);
        wait_cyc(84);
        check_com(3, 79);
        check("rd_cnt_long", 32'(rd_cnt), 32'd20);

        // Reset mid-packet: outputs clear without a clock edge.
        buffer.push_back(8'hAA);
        buffer.push_back(8'hBB);
        buffer.push_back(8'hCC);
        push_exp(START_C, 1'b0, 1'b1);
        push_exp(8'hAA, 1'b1, 1'b0);
        wait_cyc(90);
        req_pkt(3, 90);
        wait_cyc(93);
        check("mid_dout", {22'd0, d_out, valid, k_out, busy}, {22'd0, 8'hBB, 1'b1, 1'b0, 1'b1});
        reset = 1'b1;
        #1;
        check("async_rst", {22'd0, d_out, valid, k_out, busy}, 32'd0);
        buffer.delete();
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst", {22'd0, d_out, valid, k_out, busy}, 32'd0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/tx_framer_mux.md
Name: tx_framer_mux

Overview:
- Parametrised successor to the lane symbol mux in the transmit path.
- Replaces the externally driven 2-bit select with an internal framing FSM. The FSM wraps each packet from the transmit data buffer in start and end characters.
- Periodically inserts a COM-led ordered set between packets; otherwise emits idle symbols.
- Sits between the transmit data buffer and the per-lane encoder; the output register feeds the encoder directly.

Parameters:
- DATA_W, 8, symbol width in bits.
- LEN_W, 4, width of the packet-length field; max packet is 2^LEN_W-1 data symbols.
- SKP_INTERVAL, 16, cycles between ordered-set insertion opportunities (>=2).
- OS_LEN, 4, ordered-set length in symbols including COM (>=2).

Ports:
- clk  in  1  symbol clock, rising edge only.
- reset  in  1  asynchronous, active-high.
- pkt_req  in  1  packet ready in buffer; held high until pkt_ack.
- pkt_len  in  LEN_W  data-symbol count of the requested packet; sampled on ack.
- pkt_ack  out  1  combinational; high in the cycle the request is accepted.
- D_in  in  DATA_W  head of the transmit data buffer.
- data_rd  out  1  combinational pop strobe; D_in is consumed at the edge ending each cycle where it is high.
- start_end  in  2*DATA_W  [DATA_W-1:0] start character, [2*DATA_W-1:DATA_W] end character.
- ordered_set  in  DATA_W  fill symbol for ordered-set positions after COM.
- logical_COM  in  DATA_W  COM symbol.
- D_out  out  DATA_W  registered output symbol.
- valid  out  1  registered; 1 only when D_out carries buffer data.
- k_out  out  1  registered; 1 when D_out is a control symbol (start, end, COM, ordered-set fill).
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous):
  - D_out=0, valid=0, k_out=0; FSM=IDLE.
  - Skip timer=0, length counter=0, OS counter=0.
  - Takes effect immediately, including mid-packet or mid-ordered-set. The partial frame is abandoned; no end character is emitted.
- Skip timer:
  - Increments every cycle and saturates at SKP_INTERVAL-1.
  - skp_due = (timer==SKP_INTERVAL-1).
  - Cleared to 0 on the edge that emits COM.
  - While a packet is in progress, the timer saturates; an ordered set is never inserted inside a packet.
- FSM states and per-edge behaviour (D_out, valid, k_out are loaded at each rising edge according to the state during the preceding cycle):
  - IDLE, skp_due=1: D_out<=logical_COM, k_out<=1, valid<=0; OS counter<=OS_LEN-1; ->OS. skp_due has priority over pkt_req; pkt_ack stays 0.
  - IDLE, pkt_req=1, skp_due=0: pkt_ack=1; D_out<=start character, k_out<=1, valid<=0. Latches pkt_len into the length counter; ->DATA if pkt_len!=0, else ->END.
  - IDLE, otherwise: D_out<=0, valid<=0, k_out<=0; stay in IDLE.
  - OS: D_out<=ordered_set, k_out<=1, valid<=0; OS counter decrements; ->IDLE when the counter was 1.
  - DATA: data_rd=1; D_out<=D_in, valid<=1, k_out<=0; length counter decrements; ->END when the counter was 1.
  - END: D_out<=end character, k_out<=1, valid<=0; ->IDLE.
- Latency: one cycle from acceptance to the start character on D_out. Data symbols follow in consecutive cycles with no bubbles.
- Back-to-back packets: after END, the next IDLE cycle may accept immediately, so the next start character directly follows the end character (unless skp_due).
- pkt_req deasserted before ack: no effect. pkt_len changes after ack: ignored.
- data_rd and pkt_ack are never high outside DATA and IDLE respectively.
- valid and k_out are never both 1.

Test Plan:
- Reset: assert reset mid-DATA with D_out=0xBB -> outputs go 0 immediately without a clock; after release FSM is IDLE and D_out=0 on the next edge.
- Single packet: pkt_req with pkt_len=3, D_in=AA,BB,CC -> D_out=start, AA, BB, CC, end on consecutive edges. valid=0,1,1,1,0; k_out=1,0,0,0,1; data_rd high for exactly 3 cycles.
- Zero length: pkt_len=0 -> start then end on consecutive edges; data_rd never asserts.
- Ordered set (defaults): idle after reset -> first COM on the 16th edge after release, followed by 3 ordered_set symbols (k_out=1); then idle zeros; the next COM arrives 16 cycles after the first.
- Collision: pkt_req high in the cycle skp_due=1 -> COM plus 3 fill symbols first with pkt_ack=0; the packet is acked on the first IDLE cycle after the ordered set.
- Long packet: pkt_len=15 started 2 cycles before skp_due -> no COM inside the packet; COM directly follows the end character.
